// File: rtl/buffer_transfer_splitter_if.sv
// Handshake bundle between the buffer transfer splitter and its surroundings:
// descriptor in, memory-write requests and acks, and the completion report.
interface buffer_transfer_splitter_if #(
  parameter int VADDR_BITS = 32,
  parameter int LEN_BITS   = 17
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [VADDR_BITS-1:0] desc_vaddr;
  logic [27:0]           desc_size;
  logic [2:0]            desc_type;

  logic                  req_valid;
  logic                  req_ready;
  logic [VADDR_BITS-1:0] req_vaddr;
  logic [LEN_BITS-1:0]   req_len;
  logic                  req_last;
  logic                  ack;

  logic                  done_valid;
  logic                  done_ready;
  logic [27:0]           done_bytes;
  logic                  done_error;

  // master is the splitter's view, slave is the environment driving it
  modport master (
    input  desc_valid, desc_vaddr, desc_size, desc_type, req_ready, ack, done_ready,
    output desc_ready, req_valid, req_vaddr, req_len, req_last,
           done_valid, done_bytes, done_error
  );

  modport slave (
    output desc_valid, desc_vaddr, desc_size, desc_type, req_ready, ack, done_ready,
    input  desc_ready, req_valid, req_vaddr, req_len, req_last,
           done_valid, done_bytes, done_error
  );
endinterface

// File: rtl/buffer_transfer_splitter.sv
// Splits one buffer descriptor into memory-write requests of at most TRANSFER_SIZE
// bytes, limits outstanding requests, and reports completion once all are acked.
module buffer_transfer_splitter #(
  parameter int TRANSFER_SIZE   = 65536,
  parameter int MAX_OUTSTANDING = 4,
  parameter int VADDR_BITS      = 32,
  parameter int LEN_BITS        = $clog2(TRANSFER_SIZE) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  buffer_transfer_splitter_if.master bus
);

  localparam int              OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [27:0]     XFER    = 28'(TRANSFER_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [VADDR_BITS-1:0] cur_vaddr, cur_vaddr_nxt;
  logic [27:0]           remaining, remaining_nxt;
  logic [27:0]           total, total_nxt;
  logic [OW-1:0]         outstanding, outstanding_nxt;
  logic                  err, err_nxt;

  logic [27:0]           align_mask;
  logic [27:0]           aligned;
  logic                  req_hs;
  logic                  ack_live;
  logic                  spurious;
  logic                  fits;

  // Element width drives the round-down; invalid types are rejected before use
  always_comb begin
    align_mask = 28'hFFF_FFFF;
    case (bus.desc_type)
      3'd1, 3'd3: align_mask = 28'hFFF_FFFC;
      3'd2, 3'd4: align_mask = 28'hFFF_FFF8;
      default:    align_mask = 28'hFFF_FFFF;
    endcase
    aligned = bus.desc_size & align_mask;
  end

  assign fits           = (remaining <= XFER);
  assign bus.desc_ready = (state == IDLE);
  assign bus.req_valid  = (state == ISSUE) && (outstanding < MAX_OUT);
  assign bus.req_vaddr  = cur_vaddr;
  assign bus.req_len    = fits ? LEN_BITS'(remaining) : LEN_BITS'(XFER);
  assign bus.req_last   = (state == ISSUE) && fits;
  assign bus.done_valid = (state == DONE);
  assign bus.done_bytes = total;
  assign bus.done_error = err;

  assign req_hs   = bus.req_valid && bus.req_ready;
  assign ack_live = bus.ack && ((state == ISSUE) || (state == DRAIN));

  // Outstanding window: an ack with nothing outstanding is flagged instead of underflowing
  always_comb begin
    outstanding_nxt = outstanding;
    spurious        = 1'b0;
    if (req_hs && !ack_live) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!req_hs && ack_live) begin
      if (outstanding == '0) begin
        spurious = 1'b1;
      end else begin
        outstanding_nxt = outstanding - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_vaddr_nxt = cur_vaddr;
    remaining_nxt = remaining;
    total_nxt     = total;
    err_nxt       = err;
    case (state)
      IDLE: begin
        if (bus.desc_valid) begin
          cur_vaddr_nxt = bus.desc_vaddr;
          if (bus.desc_type > 3'd4) begin
            err_nxt       = 1'b1;
            total_nxt     = '0;
            remaining_nxt = '0;
            state_nxt     = DONE;
          end else if (aligned == '0) begin
            total_nxt     = '0;
            remaining_nxt = '0;
            state_nxt     = DONE;
          end else begin
            total_nxt     = aligned;
            remaining_nxt = aligned;
            state_nxt     = ISSUE;
          end
        end
      end
      ISSUE: begin
        err_nxt = err || spurious;
        if (req_hs) begin
          remaining_nxt = remaining - 28'(bus.req_len);
          cur_vaddr_nxt = cur_vaddr + VADDR_BITS'(bus.req_len);
          if (bus.req_last) begin
            state_nxt = DRAIN;
          end
        end
      end
      // Looking at the next count lets the final ack raise done_valid one cycle later
      DRAIN: begin
        err_nxt = err || spurious;
        if (outstanding_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.done_ready) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_vaddr   <= '0;
      remaining   <= '0;
      total       <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_vaddr   <= cur_vaddr_nxt;
      remaining   <= remaining_nxt;
      total       <= total_nxt;
      outstanding <= outstanding_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_buffer_transfer_splitter.sv
// Scoreboard bench for buffer_transfer_splitter: a reference split model queues the
// expected requests and completions, a negedge monitor pops and compares them.
module tb_buffer_transfer_splitter;

  localparam int VB = 32;
  localparam int LB = 17;
  localparam int TS = 65536;

  typedef struct packed {
    logic [VB-1:0] vaddr;
    logic [LB-1:0] len;
    logic          last;
  } req_t;

  typedef struct packed {
    logic [27:0] bytes;
    logic        err;
  } done_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  buffer_transfer_splitter_if #(.VADDR_BITS(VB), .LEN_BITS(LB)) bus ();

  buffer_transfer_splitter #(
    .TRANSFER_SIZE  (TS),
    .MAX_OUTSTANDING(2),
    .VADDR_BITS     (VB),
    .LEN_BITS       (LB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  req_t  req_q[$];
  done_t done_q[$];
  req_t  mon_req;
  done_t mon_done;
  logic  mon_has;
  int    n_checks   = 0;
  int    n_pass     = 0;
  int    hs_count   = 0;
  int    done_count = 0;
  int    acks_sent  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both handshakes are sampled mid-cycle, where DUT outputs and bench inputs are settled
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_valid && bus.req_ready) begin
        mon_has = (req_q.size() != 0);
        checkOutput("req_expected", 64'(mon_has), 64'd1);
        if (mon_has) begin
          mon_req = req_q.pop_front();
          checkOutput("req_vaddr", 64'(bus.req_vaddr), 64'(mon_req.vaddr));
          checkOutput("req_len",   64'(bus.req_len),   64'(mon_req.len));
          checkOutput("req_last",  64'(bus.req_last),  64'(mon_req.last));
        end
        hs_count++;
      end
      if (bus.done_valid && bus.done_ready) begin
        mon_has = (done_q.size() != 0);
        checkOutput("done_expected", 64'(mon_has), 64'd1);
        if (mon_has) begin
          mon_done = done_q.pop_front();
          checkOutput("done_bytes", 64'(bus.done_bytes), 64'(mon_done.bytes));
          checkOutput("done_error", 64'(bus.done_error), 64'(mon_done.err));
        end
        done_count++;
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_desc_ready", 64'(bus.desc_ready), 64'd1);
    checkOutput("rst_req_valid",  64'(bus.req_valid),  64'd0);
    checkOutput("rst_req_vaddr",  64'(bus.req_vaddr),  64'd0);
    checkOutput("rst_req_len",    64'(bus.req_len),    64'd0);
    checkOutput("rst_req_last",   64'(bus.req_last),   64'd0);
    checkOutput("rst_done_valid", 64'(bus.done_valid), 64'd0);
    checkOutput("rst_done_bytes", 64'(bus.done_bytes), 64'd0);
    checkOutput("rst_done_error", 64'(bus.done_error), 64'd0);
  endtask

  // Queues the model's expectations, then hands the descriptor over and checks first-cycle latency
  task automatic applyStimulus(input logic [VB-1:0] va, input logic [27:0] sz,
                               input logic [2:0] ty, input logic extra_err);
    int            w;
    int            nreq;
    logic [27:0]   al;
    logic [27:0]   rem;
    logic [27:0]   l;
    logic [VB-1:0] a;
    req_t          r;
    done_t         d;
    nreq = 0;
    w    = (ty == 3'd0) ? 1 : ((ty == 3'd1 || ty == 3'd3) ? 4 : 8);
    al   = 28'(int'(sz) - (int'(sz) % w));
    if (ty > 3'd4) begin
      d.bytes = '0;
      d.err   = 1'b1;
    end else begin
      rem = al;
      a   = va;
      while (rem != 0) begin
        l       = (rem > 28'(TS)) ? 28'(TS) : rem;
        r.vaddr = a;
        r.len   = LB'(l);
        r.last  = (rem <= 28'(TS));
        req_q.push_back(r);
        a   = a + VB'(l);
        rem = rem - l;
        nreq++;
      end
      d.bytes = al;
      d.err   = extra_err;
    end
    done_q.push_back(d);
    bus.desc_vaddr = va;
    bus.desc_size  = sz;
    bus.desc_type  = ty;
    bus.desc_valid = 1'b1;
    checkOutput("desc_ready", 64'(bus.desc_ready), 64'd1);
    tick();
    bus.desc_valid = 1'b0;
    if (nreq > 0) checkOutput("first_req_latency", 64'(bus.req_valid), 64'd1);
    else          checkOutput("done_latency",      64'(bus.done_valid), 64'd1);
  endtask

  // Acks every issued request one cycle later and waits for the completion handshake
  task automatic runToDone(input int budget);
    int start;
    start          = done_count;
    bus.req_ready  = 1'b1;
    bus.done_ready = 1'b1;
    for (int i = 0; i < budget && done_count == start; i++) begin
      if (hs_count > acks_sent) begin
        bus.ack = 1'b1;
        acks_sent++;
      end else begin
        bus.ack = 1'b0;
      end
      tick();
    end
    bus.ack        = 1'b0;
    bus.req_ready  = 1'b0;
    bus.done_ready = 1'b0;
    checkOutput("done_seen", 64'(done_count - start), 64'd1);
    checkOutput("desc_ready_after_done", 64'(bus.desc_ready), 64'd1);
  endtask

  initial begin
    int hs0;
    rst            = 1'b1;
    bus.desc_valid = 1'b0;
    bus.desc_vaddr = '0;
    bus.desc_size  = '0;
    bus.desc_type  = '0;
    bus.req_ready  = 1'b0;
    bus.ack        = 1'b0;
    bus.done_ready = 1'b0;
    tick();
    tick();
    checkResetValues();
    rst = 1'b0;
    tick();

    $display("[TB] multi-request split");
    applyStimulus(32'h0000_1000, 28'd150000, 3'd1, 1'b0);
    runToDone(40);

    $display("[TB] alignment");
    applyStimulus(32'h0000_5000, 28'd10, 3'd2, 1'b0);
    runToDone(20);
    applyStimulus(32'h0000_6000, 28'd7, 3'd2, 1'b0);
    runToDone(20);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_8000, 28'd131072, 3'd0, 1'b0);
    runToDone(30);

    $display("[TB] invalid type");
    hs0 = hs_count;
    applyStimulus(32'h0000_7000, 28'd4096, 3'd6, 1'b0);
    runToDone(20);
    checkOutput("invalid_no_requests", 64'(hs_count - hs0), 64'd0);

    $display("[TB] window limit");
    hs0           = hs_count;
    bus.req_ready = 1'b1;
    applyStimulus(32'h0004_0000, 28'd262144, 3'd0, 1'b0);
    repeat (4) tick();
    checkOutput("window_full_count", 64'(hs_count - hs0), 64'd2);
    checkOutput("window_full_valid", 64'(bus.req_valid), 64'd0);
    bus.ack = 1'b1;
    acks_sent++;
    tick();
    checkOutput("window_reopen", 64'(bus.req_valid), 64'd1);
    acks_sent++;
    tick();
    bus.ack = 1'b0;
    checkOutput("ack_with_hs_valid", 64'(bus.req_valid), 64'd1);
    checkOutput("ack_with_hs_count", 64'(hs_count - hs0), 64'd3);
    runToDone(40);

    $display("[TB] spurious ack in drain");
    bus.req_ready = 1'b1;
    applyStimulus(32'h0000_2000, 28'd8, 3'd0, 1'b1);
    bus.ack = 1'b1;
    acks_sent++;
    tick();
    tick();
    bus.ack = 1'b0;
    runToDone(20);

    $display("[TB] backpressure");
    bus.req_ready = 1'b0;
    applyStimulus(32'h8000_0000, 28'd150000, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(bus.req_valid), 64'd1);
      checkOutput("stall_vaddr", 64'(bus.req_vaddr), 64'(req_q[0].vaddr));
      checkOutput("stall_len",   64'(bus.req_len),   64'(req_q[0].len));
      checkOutput("stall_last",  64'(bus.req_last),  64'(req_q[0].last));
      tick();
    end
    runToDone(40);

    $display("[TB] reset during issue");
    bus.req_ready = 1'b1;
    applyStimulus(32'h0000_0100, 28'd262144, 3'd0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkResetValues();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_ready = 1'b0;
    req_q.delete();
    done_q.delete();
    hs_count  = 0;
    acks_sent = 0;
    tick();
    applyStimulus(32'h0000_3000, 28'd65536, 3'd0, 1'b0);
    runToDone(20);

    checkOutput("req_queue_drained",  64'(req_q.size()),  64'd0);
    checkOutput("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/buffer_transfer_splitter.md
# buffer_transfer_splitter

Splits one host buffer descriptor (virtual address, allocation size, element type) into a sequence of memory-write requests of at most TRANSFER_SIZE bytes each. It tracks per-request acknowledgements under a bounded outstanding window and reports completion once every issued request has been acknowledged. It sits between the configuration path, which supplies buffer descriptors, and the output writer's memory request interface. It generalises the fixed 64 KiB transfer granularity into a parameter, adds element-type alignment, and adds flow control on outstanding requests.

## Interface
- TRANSFER_SIZE, 65536: maximum bytes per request; power of two, ≥ 8.
- MAX_OUTSTANDING, 4: maximum requests issued but not yet acknowledged; 1..64.
- LEN_BITS, $clog2(TRANSFER_SIZE)+1: width of the request length field.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- desc_valid / desc_ready  in / out  1 / 1  descriptor handshake.
- desc_vaddr  in  VADDR_BITS  buffer base virtual address.
- desc_size  in  28  allocation size in bytes (alloc_size_t).
- desc_type  in  3  element type (type_t encoding: 0 = BYTE, 1 = INT32, 2 = INT64, 3 = FLOAT, 4 = DOUBLE).
- req_valid / req_ready  out / in  1 / 1  request handshake.
- req_vaddr  out  VADDR_BITS  request start address.
- req_len  out  LEN_BITS  request length in bytes.
- req_last  out  1  marks the final request of the descriptor.
- ack  in  1  single-cycle pulse; one request completed.
- done_valid / done_ready  out / in  1 / 1  completion handshake.
- done_bytes  out  28  total bytes issued for the descriptor.
- done_error  out  1  invalid type or spurious ack seen during this descriptor.

## Operation
- The state machine has four states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE.** desc_ready = 1. On desc_valid, the block latches the address and computes the aligned size: desc_size rounded down to a multiple of the element width in bytes (1, 4 or 8).
  - Aligned size 0 → go to DONE with done_bytes = 0.
  - desc_type in 5..7 → go to DONE with done_error = 1 and done_bytes = 0.
  - Otherwise → go to ISSUE.
- **ISSUE.** req_valid = 1 whenever outstanding < MAX_OUTSTANDING.
  - req_len = min(TRANSFER_SIZE, remaining).
  - req_vaddr = base + bytes issued so far.
  - req_last = 1 when remaining ≤ TRANSFER_SIZE.
  - On each req handshake: remaining -= req_len, the address advances by req_len, outstanding += 1.
  - The last handshake moves to DRAIN.
- **DRAIN.** Wait until outstanding = 0, then go to DONE.
- **DONE.** done_valid = 1 and holds until done_ready; then return to IDLE.
- **Outstanding counter.**
  - Width $clog2(MAX_OUTSTANDING+1).
  - Increments on req handshake and decrements on ack; both in the same cycle leaves it unchanged.
  - An ack while the counter is 0 (and no simultaneous handshake) is ignored and sets sticky done_error.
  - Acks in IDLE or DONE are ignored and do not set the error.
- req outputs stay stable while req_valid = 1 and req_ready = 0.
- **Address arithmetic.** VADDR_BITS wide; wraps modulo 2^VADDR_BITS with no error.
- done_error clears on entry to IDLE.

## Timing
- **Reset values.** State IDLE; desc_ready = 1; req_valid = 0; req_vaddr = 0, req_len = 0, req_last = 0; done_valid = 0, done_bytes = 0, done_error = 0; internal counters 0.
- **Latency.** A descriptor accepted in cycle N gives the first req_valid in N+1.
  - Back-to-back requests at one per cycle while req_ready = 1 and the window is not full.
- **Window stall.** req_valid is computed from the registered outstanding count. An ack in cycle N reopens a full window at N+1.
- **Completion.** The final ack in cycle N gives done_valid in N+1.
  - Zero-size or invalid descriptors: done_valid in N+1 after acceptance.
- **Next descriptor.** The done handshake in cycle N gives desc_ready = 1 in N+1.
- **Reset mid-operation.** rst asserted in any state returns all state and outputs to reset values immediately (asynchronous). Outstanding requests are abandoned.

## Test plan
- **Multi-request split.** TRANSFER_SIZE = 65536, size 150000, INT32, vaddr 0x1000 → three requests:
  - (0x1000, 65536, last 0)
  - (0x11000, 65536, last 0)
  - (0x21000, 18928, last 1)
  - After 3 acks: done_bytes = 150000, done_error = 0.
- **Alignment.** size 10, INT64 → one request, len 8, last 1; done_bytes = 8. Size 7, INT64 → no request; done_bytes = 0, done_valid one cycle after acceptance.
- **Window limit.** MAX_OUTSTANDING = 2, size 262144, BYTE, req_ready held high, no acks → exactly 2 requests, then req_valid = 0.
  - One ack → the third request issues the next cycle.
  - Ack coincident with a handshake → counter unchanged.
- **Errors.**
  - desc_type = 6 → done_error = 1, 0 requests.
  - An extra ack during DRAIN with outstanding = 0 → done_error = 1, done_bytes still correct.
- **Backpressure and reset.**
  - req_ready low for 5 cycles → req fields stable.
  - rst pulsed during ISSUE → outputs at reset values; a following descriptor of 65536 bytes completes normally.
